// File: rtl/y86_dmem_responder_if.sv
// Request/response bus between the Y86 memory stage (master) and its data memory (slave).
interface y86_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/y86_dmem_responder.sv
// Byte-addressed little-endian data memory with fixed access latency for the Y86 memory stage.
// Define DMEM_BOUNDS_CHECK_EN to flag out-of-range accesses instead of wrapping them.
module y86_dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    y86_dmem_responder_if.slave    bus,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic        busy_q;
    logic [63:0] rsp_rdata_q;

    logic        wr_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;

    logic [7:0]  mem_q [DEPTH];

    logic        accept;
    logic        acc_fire;
    logic        acc_write;
    logic        acc_ok;
    logic [63:0] acc_addr;
    logic [63:0] acc_wdata;
    logic [63:0] acc_rdata;
    logic [63:0] rsp_rdata_d;
    logic        rsp_error_d;

    function automatic logic [AW-1:0] byte_idx(input logic [AW-1:0] a, input int k);
        return a + AW'(k);
    endfunction

    assign accept = bus.req_valid && req_ready_q;

    // With LATENCY==1 the access happens on the accepting edge, straight from the request bus.
    always_comb begin
        acc_fire  = 1'b0;
        acc_write = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE && LATENCY == 1 && accept) begin
            acc_fire  = 1'b1;
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end else if (state_q == WAIT && cnt_q == 4'd1) begin
            acc_fire = 1'b1;
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    assign acc_ok = (acc_addr <= 64'(DEPTH - 8));
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[63:AW];
    assign acc_ok = 1'b1;
`endif

    always_comb begin
        acc_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            acc_rdata[8*k +: 8] = mem_q[byte_idx(acc_addr[AW-1:0], k)];
        end
    end

    assign rsp_rdata_d = (acc_ok && !acc_write) ? acc_rdata : '0;
    assign rsp_error_d = !acc_ok;

    // A reset on the access edge discards the write; a committed write is never undone.
    always_ff @(posedge clk) begin
        if (rst_n && acc_fire && acc_write && acc_ok) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[byte_idx(acc_addr[AW-1:0], k)] <= acc_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && accept) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= WAIT;
                        cnt_q       <= 4'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_error_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (acc_fire) begin
                state_q     <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rsp_rdata_d;
                rsp_error_q <= rsp_error_d;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_y86_dmem_responder.sv
// Bench for y86_dmem_responder: three instances (LATENCY 2, 1, 3) sharing request fields,
// table vectors plus random traffic on the LATENCY=2 instance against a byte-array model.
module tb_y86_dmem_responder;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // index 0: LATENCY=2, 1: LATENCY=1, 2: LATENCY=3
    logic [2:0]  rv;
    logic [2:0]  rr;
    logic        wr_s;
    logic [63:0] addr_s;
    logic [63:0] wd_s;
    logic [2:0]  o_rdy, o_vld, o_err, o_busy;
    logic [63:0] o_rd [3];
    logic        busy2, busy1, busy3;

    y86_dmem_responder_if if2();
    y86_dmem_responder_if if1();
    y86_dmem_responder_if if3();

    assign if2.req_valid = rv[0];
    assign if2.req_write = wr_s;
    assign if2.req_addr  = addr_s;
    assign if2.req_wdata = wd_s;
    assign if2.rsp_ready = rr[0];
    assign if1.req_valid = rv[1];
    assign if1.req_write = wr_s;
    assign if1.req_addr  = addr_s;
    assign if1.req_wdata = wd_s;
    assign if1.rsp_ready = rr[1];
    assign if3.req_valid = rv[2];
    assign if3.req_write = wr_s;
    assign if3.req_addr  = addr_s;
    assign if3.req_wdata = wd_s;
    assign if3.rsp_ready = rr[2];

    assign o_rdy  = {if3.req_ready, if1.req_ready, if2.req_ready};
    assign o_vld  = {if3.rsp_valid, if1.rsp_valid, if2.rsp_valid};
    assign o_err  = {if3.rsp_error, if1.rsp_error, if2.rsp_error};
    assign o_busy = {busy3, busy1, busy2};
    assign o_rd[0] = if2.rsp_rdata;
    assign o_rd[1] = if1.rsp_rdata;
    assign o_rd[2] = if3.rsp_rdata;

    y86_dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave), .busy(busy2));
    y86_dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1));
    y86_dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave), .busy(busy3));

    // Reference memory for the LATENCY=2 instance.
    logic [7:0] ref_mem [DEPTH];

    function automatic void mdl(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                                output logic [63:0] rd, output logic er);
        logic ok;
        int   idx;
        ok = 1'b1;
`ifdef DMEM_BOUNDS_CHECK_EN
        ok = (a <= 64'(DEPTH - 8));
`endif
        rd = '0;
        er = !ok;
        if (ok) begin
            for (int k = 0; k < 8; k++) begin
                idx = int'((a + 64'(k)) % 64'(DEPTH));
                if (wr) ref_mem[idx] = wd[8*k +: 8];
                else    rd[8*k +: 8] = ref_mem[idx];
            end
        end
    endfunction

    function automatic logic [63:0] peek(input int a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[(a + k) % DEPTH];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input int d, input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [63:0] exp_rd, input logic [63:0] mask, input logic exp_err,
                           input int exp_lat, input int hold, input string nm);
        int n;
        rr[d]  = (hold == 0);
        wr_s   = wr;
        addr_s = addr;
        wd_s   = wd;
        rv[d]  = 1'b1;
        n = 0;
        while (!o_rdy[d] && n < 40) begin tick(); n++; end
        chk({nm, "_req_ready"}, 64'(o_rdy[d]), 64'd1);
        tick();
        acc_cyc = cyc;
        rv[d]  = 1'b0;
        wr_s   = ~wr;
        addr_s = {$urandom, $urandom};
        wd_s   = {$urandom, $urandom};
        n = 0;
        while (!o_vld[d] && n < 40) begin tick(); n++; end
        chk({nm, "_rsp_valid"}, 64'(o_vld[d]), 64'd1);
        chk({nm, "_latency"}, 64'(n + 1), 64'(exp_lat));
        chk({nm, "_rdata"}, o_rd[d] & mask, exp_rd & mask);
        chk({nm, "_error"}, 64'(o_err[d]), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({nm, "_hold_valid"}, 64'(o_vld[d]), 64'd1);
            chk({nm, "_hold_rdata"}, o_rd[d] & mask, exp_rd & mask);
            chk({nm, "_hold_ready"}, 64'(o_rdy[d]), 64'd0);
        end
        rr[d] = 1'b1;
        tick();
    endtask

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rd;
        logic [63:0] mask;
        logic        err;
    } vec_t;

    function automatic vec_t mkv(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                                 input logic [63:0] rd, input logic [63:0] m, input logic e);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = wd; v.rd = rd; v.mask = m; v.err = e;
        return v;
    endfunction

    initial begin
        vec_t        tbl[$];
        logic [63:0] erd, wd, a, a_val;
        logic        eer, w;
        int          n, a0, cls, hold;

        rv = '0; rr = 3'b111; wr_s = 1'b0; addr_s = '0; wd_s = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", 64'(o_rdy), 64'h7);
        chk("rst_rsp_valid", 64'(o_vld), 64'h0);
        chk("rst_rsp_error", 64'(o_err), 64'h0);
        chk("rst_busy", 64'(o_busy), 64'h0);
        chk("rst_rdata", o_rd[0], 64'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < DEPTH / 8; i++) begin
            wd = {$urandom, $urandom};
            mdl(1'b1, 64'(i * 8), wd, erd, eer);
            run_txn(0, 1'b1, 64'(i * 8), wd, 64'h0, '1, 1'b0, 2, 0, "preload");
        end

        tbl.push_back(mkv(1, 64'h40, 64'h1122334455667788, 64'h0, '1, 0));
        tbl.push_back(mkv(0, 64'h40, 64'h0, 64'h1122334455667788, '1, 0));
        tbl.push_back(mkv(0, 64'h41, 64'h0, {ref_mem[8'h48], 56'h11223344556677}, '1, 0));
        tbl.push_back(mkv(0, 64'h40, 64'h0, 64'h88, 64'hFF, 0));
`ifdef DMEM_BOUNDS_CHECK_EN
        tbl.push_back(mkv(1, 64'h3F9, 64'hDEADBEEFCAFEF00D, 64'h0, '1, 1));
        tbl.push_back(mkv(0, 64'h3F8, 64'h0, peek(32'h3F8), '1, 0));
        tbl.push_back(mkv(0, 64'h3F9, 64'h0, 64'h0, '1, 1));
        tbl.push_back(mkv(0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, '1, 1));
`else
        tbl.push_back(mkv(1, 64'h3FC, 64'hAABBCCDD00112233, 64'h0, '1, 0));
        tbl.push_back(mkv(0, 64'h3FC, 64'h0, 64'hAABBCCDD00112233, '1, 0));
        tbl.push_back(mkv(0, 64'h000, 64'h0, 64'h00000000AABBCCDD, 64'h00000000FFFFFFFF, 0));
        tbl.push_back(mkv(0, 64'h3F8, 64'h0, 64'h0011223300000000, 64'hFFFFFFFF00000000, 0));
`endif
        foreach (tbl[i]) begin
            mdl(tbl[i].wr, tbl[i].addr, tbl[i].wdata, erd, eer);
            run_txn(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].mask, tbl[i].err,
                    2, 0, $sformatf("vec%0d", i));
        end

        // Backpressure: response held 5 cycles while a second request waits.
        mdl(1'b0, 64'h40, 64'h0, a_val, eer);
        rr[0] = 1'b0; wr_s = 1'b0; addr_s = 64'h40; rv[0] = 1'b1;
        tick();
        addr_s = 64'h48;
        n = 0;
        while (!o_vld[0] && n < 40) begin tick(); n++; end
        chk("bp_latency", 64'(n + 1), 64'd2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(o_vld[0]), 64'd1);
            chk("bp_rdata", o_rd[0], a_val);
            chk("bp_error", 64'(o_err[0]), 64'd0);
            chk("bp_req_ready", 64'(o_rdy[0]), 64'd0);
            tick();
        end
        rr[0] = 1'b1;
        tick();
        chk("bp_done_valid", 64'(o_vld[0]), 64'd0);
        chk("bp_done_ready", 64'(o_rdy[0]), 64'd1);
        chk("bp_done_busy", 64'(o_busy[0]), 64'd0);
        tick();
        chk("bp_next_accepted", 64'(o_rdy[0]), 64'd0);
        chk("bp_next_busy", 64'(o_busy[0]), 64'd1);
        rv[0] = 1'b0;
        mdl(1'b0, 64'h48, 64'h0, erd, eer);
        n = 0;
        while (!o_vld[0] && n < 40) begin tick(); n++; end
        chk("bp_next_latency", 64'(n + 1), 64'd2);
        chk("bp_next_rdata", o_rd[0], erd);
        tick();

        for (int i = 0; i < 120; i++) begin
            cls = $urandom_range(0, 3);
            case (cls)
                0, 1:    a = 64'($urandom_range(0, DEPTH - 1));
                2:       a = 64'(DEPTH - 12 + $urandom_range(0, 11));
                default: a = {$urandom, $urandom};
            endcase
            w    = 1'($urandom);
            wd   = {$urandom, $urandom};
            hold = $urandom_range(0, 2);
            mdl(w, a, wd, erd, eer);
            run_txn(0, w, a, wd, erd, '1, eer, 2, hold, "rand");
        end

        for (int i = 0; i < 4; i++) begin
            wd = {$urandom, $urandom};
            run_txn(1, 1'b1, 64'h10, wd, 64'h0, '1, 1'b0, 1, 0, "l1_wr");
            a0 = acc_cyc;
            run_txn(1, 1'b0, 64'h10, 64'h0, wd, '1, 1'b0, 1, 0, "l1_rd");
            chk("l1_period", 64'(acc_cyc - a0), 64'd2);
        end

        a_val = 64'h0F1E2D3C4B5A6978;
        run_txn(2, 1'b1, 64'h80, a_val, 64'h0, '1, 1'b0, 3, 0, "l3_wr");
        wr_s = 1'b1; addr_s = 64'h80; wd_s = 64'h5555AAAA5555AAAA; rv[2] = 1'b1;
        tick();
        rv[2] = 1'b0;
        chk("l3_busy_before_rst", 64'(o_busy[2]), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("l3_rst_ready", 64'(o_rdy[2]), 64'd1);
        chk("l3_rst_valid", 64'(o_vld[2]), 64'd0);
        chk("l3_rst_busy", 64'(o_busy[2]), 64'd0);
        run_txn(2, 1'b0, 64'h80, 64'h0, a_val, '1, 1'b0, 3, 0, "l3_rd_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/y86_dmem_responder.md
Name: y86_dmem_responder

Overview:
- Data-memory responder for the Y86 pipeline's memory stage; it is the target side of the memory stage's load/store requests.
- Accepts one read or write request at a time over a valid/ready request channel.
- Models a byte-addressed, little-endian 64-bit data memory with fixed, configurable access latency.
- Returns a read-data or write-acknowledge response over a valid/ready response channel; out-of-range accesses produce an error response (the dmem_error source for the status logic).

Parameters:
- DEPTH, 1024, memory size in bytes; power of two, >= 16.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store (rmmovq/pushq/call), 0 = load (mrmovq/popq/ret).
- req_addr  input  64  byte address, unaligned allowed.
- req_wdata  input  64  store data (valA/valP from the memory stage).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  64  load data (valM); 0 for writes and for errors.
- rsp_error  output  1  access out of range.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, latency counter=0.
  - Memory array contents are not altered by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge N: latch write, addr and wdata; load counter with LATENCY-1.
  - Go to WAIT, or directly to RESP if LATENCY==1.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter==1 at an edge, perform the access and go to RESP.
  - Result: rsp_valid first samples high at edge N+LATENCY.
- Access, performed on the edge that enters RESP:
  - Byte index i_k = addr+k, k=0..7.
  - Read: rsp_rdata[8k+7:8k] = mem[i_k], little-endian.
  - Write: mem[i_k] = wdata[8k+7:8k]; rsp_rdata=0.
  - Write commit and response become visible on the same edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid=0, rsp_rdata=0, rsp_error=0; go to IDLE.
  - req_ready stays 0 for that cycle; the next request is accepted no earlier than the following edge, so there is no back-to-back overlap.
- Throughput: at most one transaction per LATENCY+1 cycles.
- Read after write to overlapping bytes: always returns the new data, because the write commits before its response.
- Reset mid-transaction:
  - Abandons WAIT/RESP and returns to IDLE.
  - A write still in WAIT is discarded (memory unchanged).
  - A write already in RESP stays committed.
- req_* inputs are ignored outside IDLE; changes to them after acceptance do not affect the transaction.

Optional Feature:
- Macro DMEM_BOUNDS_CHECK_EN.
- Defined:
  - Request is in range iff req_addr <= DEPTH-8, compared on the full 64-bit value with no overflow.
  - Out of range: rsp_error=1, rsp_rdata=0, no memory write, same latency as a normal access.
- Not defined:
  - rsp_error is constant 0.
  - Byte index = (addr+k) mod DEPTH, so accesses wrap around the array end.
  - Every request completes normally.

Test Plan:
- Write/read, LATENCY=2, rsp_ready tied 1:
  - Write addr=0x40 data=0x1122334455667788 -> rsp_valid exactly 2 cycles after acceptance, rsp_rdata=0, rsp_error=0.
  - Read 0x40 -> rsp_rdata=0x1122334455667788.
- Unaligned little-endian, after the write above:
  - Read 0x41 -> low 7 bytes = 0x11223344556677, top byte = mem[0x48].
  - Read 0x40 again -> byte 0 reads 0x88.
- Backpressure: read with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_error stable all 5 cycles; req_ready=0 and a new req_valid is not accepted; accepted only in the cycle after rsp_ready=1.
- Bounds, DEPTH=1024:
  - With DMEM_BOUNDS_CHECK_EN: write to 0x3F9 -> rsp_error=1 and mem[0x3F9..0x3FF] unchanged; read 0x3F8 -> rsp_error=0.
  - Without the macro: write 0x3FC data=0xAABBCCDD00112233 -> mem[0x3FC..0x3FF]=33,22,11,00 and mem[0x000..0x003]=DD,CC,BB,AA.
- Reset mid-write: accept write to 0x80 with LATENCY=3, assert rst_n=0 one cycle later -> after reset, req_ready=1, rsp_valid=0, busy=0; read 0x80 returns the prior contents.
- LATENCY=1: alternate write/read of 0x10 with rsp_ready=1 -> rsp_valid one cycle after each acceptance, one transaction every 2 cycles, read returns the written data.
